mac_rx_parser: RTL and testbench

Receive-side framing stage of the Ethernet MAC. It sits directly upstream of the receive FIFO. It takes the byte-wide PHY receive stream and hunts for preamble/SFD. It writes frame bytes (DA through payload, FCS stripped) into the FIFO, checks CRC-32, frame length, PHY errors and FIFO overflow, and reports one status pulse per frame.

---
 rtl/mac_rx_parser.sv | 122 ++++++++++++
 tb/tb_mac_rx_parser.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_parser.sv
// Receive framing stage: hunts preamble/SFD, forwards DA..payload to the RX FIFO
// through a 4-byte delay line (FCS stripped) and reports per-frame status.
module mac_rx_parser #(
  parameter int unsigned MIN_FRAME = 64,
  parameter int unsigned MAX_FRAME = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic        fifo_full,
  output logic [7:0]  fifo_data,
  output logic        fifo_wr,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_crc,
  output logic        err_len,
  output logic        err_phy,
  output logic        err_overflow,
  output logic [10:0] byte_count
);

  typedef enum logic [1:0] {DROP, IDLE, PREAMBLE, DATA} state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);

  state_t      state;
  logic [31:0] crc;
  logic [7:0]  dly [4];
  logic [2:0]  fill;
  logic        phy_flag;
  logic        ovf_flag;
  logic        crc_bad;
  logic        len_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    crc_bad = (crc != CRC_RESIDUE);
    len_bad = (byte_count < MIN_LEN) || (byte_count > MAX_LEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DROP;
      crc          <= '1;
      fill         <= '0;
      phy_flag     <= 1'b0;
      ovf_flag     <= 1'b0;
      fifo_data    <= '0;
      fifo_wr      <= 1'b0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      err_crc      <= 1'b0;
      err_len      <= 1'b0;
      err_phy      <= 1'b0;
      err_overflow <= 1'b0;
      byte_count   <= '0;
    end else begin
      fifo_wr    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        DROP: if (!rx_dv) state <= IDLE;
        IDLE: if (rx_dv) state <= (rx_data == 8'h55) ? PREAMBLE : DROP;
        PREAMBLE: begin
          if (!rx_dv)
            state <= IDLE;
          else if (rx_data == 8'hD5) begin
            state      <= DATA;
            crc        <= '1;
            byte_count <= '0;
            fill       <= '0;
            phy_flag   <= 1'b0;
            ovf_flag   <= 1'b0;
          end else if (rx_data != 8'h55)
            state <= DROP;
        end
        DATA: begin
          if (rx_dv) begin
            crc    <= crc_byte(crc, rx_data);
            dly[0] <= rx_data;
            dly[1] <= dly[0];
            dly[2] <= dly[1];
            dly[3] <= dly[2];
            if (byte_count != '1) byte_count <= byte_count + 11'd1;
            if (rx_er) phy_flag <= 1'b1;
            // Once four bytes are buffered, the oldest leaves on every new byte;
            // an overflow latches and blocks the rest of this frame.
            if (fill == 3'd4) begin
              if (fifo_full)
                ovf_flag <= 1'b1;
              else if (!ovf_flag) begin
                fifo_wr   <= 1'b1;
                fifo_data <= dly[3];
              end
            end else
              fill <= fill + 3'd1;
          end else begin
            frame_done   <= 1'b1;
            err_crc      <= crc_bad;
            err_len      <= len_bad;
            err_phy      <= phy_flag;
            err_overflow <= ovf_flag;
            frame_ok     <= !(crc_bad || len_bad || phy_flag || ovf_flag);
            state        <= IDLE;
          end
        end
        default: state <= DROP;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_parser.sv
// Directed self-checking bench for mac_rx_parser: builds frames with a reference
// CRC-32 FCS, drives them through the PHY interface and checks writes and status.
module tb_mac_rx_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic        fifo_full = 1'b0;
  logic [7:0]  fifo_data;
  logic        fifo_wr;
  logic        frame_done;
  logic        frame_ok;
  logic        err_crc;
  logic        err_len;
  logic        err_phy;
  logic        err_overflow;
  logic [10:0] byte_count;

  mac_rx_parser #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
    .fifo_full(fifo_full), .fifo_data(fifo_data), .fifo_wr(fifo_wr),
    .frame_done(frame_done), .frame_ok(frame_ok), .err_crc(err_crc),
    .err_len(err_len), .err_phy(err_phy), .err_overflow(err_overflow),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame_buf [2048];
  logic [7:0] wr_buf [4096];
  int wr_total = 0;
  int done_total = 0;
  int full_viol = 0;
  logic prev_full = 1'b0;
  logic d_ok, d_crc, d_len, d_phy, d_ovf;
  logic [10:0] d_bc;

  // Outputs observed at the falling edge, half a cycle after they were registered.
  always @(negedge clk) begin
    if (fifo_wr) begin
      wr_buf[wr_total % 4096] = fifo_data;
      wr_total++;
      if (prev_full) full_viol++;
    end
    prev_full = fifo_full;
    if (frame_done) begin
      done_total++;
      d_ok = frame_ok; d_crc = err_crc; d_len = err_len;
      d_phy = err_phy; d_ovf = err_overflow; d_bc = byte_count;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input int len);
    logic [31:0] c;
    logic [31:0] fcs;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      frame_buf[i] = 8'((i * 13 + 5) ^ (i >> 3));
      c = ref_crc(c, frame_buf[i]);
    end
    fcs = ~c;
    for (int k = 0; k < 4; k++)
      frame_buf[len - 4 + k] = fcs[8*k +: 8];
  endtask

  task automatic drive(input logic [7:0] b, input logic dv, input logic er, input logic full);
    @(posedge clk);
    #1;
    rx_data = b; rx_dv = dv; rx_er = er; fifo_full = full;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input int len, input int full_at, input int er_at, input int rst_at);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0, 1'b0);
    drive(8'hD5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      drive(frame_buf[i], 1'b1, (i == er_at), (i >= full_at) && (i < full_at + 3));
      rst = (i == rst_at);
      if (i == rst_at + 1) begin
        check("rst_mid_fifo_wr", 32'(fifo_wr), 0);
        check("rst_mid_byte_count", 32'(byte_count), 0);
        check("rst_mid_frame_done", 32'(frame_done), 0);
      end
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(4);
  endtask

  task automatic check_frame(input string tag, input int wr0, input int dn0, input int exp_wr,
                             input int exp_dn, input logic ok, input logic ecrc, input logic elen,
                             input logic ephy, input logic eovf, input int bc);
    int bad;
    bad = 0;
    check({tag, "_writes"}, 32'(wr_total - wr0), 32'(exp_wr));
    for (int j = 0; j < exp_wr && wr0 + j < wr_total; j++)
      if (wr_buf[(wr0 + j) % 4096] !== frame_buf[j]) bad++;
    check({tag, "_data"}, 32'(bad), 0);
    check({tag, "_done"}, 32'(done_total - dn0), 32'(exp_dn));
    if (exp_dn != 0) begin
      check({tag, "_ok"}, 32'(d_ok), 32'(ok));
      check({tag, "_crc"}, 32'(d_crc), 32'(ecrc));
      check({tag, "_len"}, 32'(d_len), 32'(elen));
      check({tag, "_phy"}, 32'(d_phy), 32'(ephy));
      check({tag, "_ovf"}, 32'(d_ovf), 32'(eovf));
      check({tag, "_bc"}, 32'(d_bc), 32'(bc));
    end
  endtask

  initial begin
    int w0, n0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fifo_wr", 32'(fifo_wr), 0);
    check("rst_fifo_data", 32'(fifo_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_ok", 32'(frame_ok), 0);
    check("rst_errs", {28'h0, err_crc, err_len, err_phy, err_overflow}, 0);
    check("rst_byte_count", 32'(byte_count), 0);
    rst = 1'b0;
    idle(3);

    // Good 64-byte frame
    build_frame(64);
    w0 = wr_total; n0 = done_total;
    run_frame(64, -10, -1, -1);
    check_frame("good64", w0, n0, 60, 1, 1, 0, 0, 0, 0, 64);

    // One payload bit flipped after the FCS was computed
    build_frame(64);
    frame_buf[20] = frame_buf[20] ^ 8'h08;
    w0 = wr_total; n0 = done_total;
    run_frame(64, -10, -1, -1);
    check_frame("crcbad", w0, n0, 60, 1, 0, 1, 0, 0, 0, 64);

    // Runt with valid FCS
    build_frame(40);
    w0 = wr_total; n0 = done_total;
    run_frame(40, -10, -1, -1);
    check_frame("short40", w0, n0, 36, 1, 0, 0, 1, 0, 0, 40);

    // Oversize frame
    build_frame(1519);
    w0 = wr_total; n0 = done_total;
    run_frame(1519, -10, -1, -1);
    check_frame("long1519", w0, n0, 1515, 1, 0, 0, 1, 0, 0, 1519);

    // FCS only: no writes, CRC still good
    build_frame(4);
    w0 = wr_total; n0 = done_total;
    run_frame(4, -10, -1, -1);
    check_frame("tiny4", w0, n0, 0, 1, 0, 0, 1, 0, 0, 4);

    // fifo_full for 3 cycles at the point of write 10 (byte 14 sampled)
    build_frame(64);
    w0 = wr_total; n0 = done_total; full_viol = 0;
    run_frame(64, 14, -1, -1);
    check_frame("overflow", w0, n0, 10, 1, 0, 0, 0, 0, 1, 64);
    check("overflow_wr_while_full", 32'(full_viol), 0);

    // Bad preamble byte then junk: dropped
    w0 = wr_total; n0 = done_total;
    drive(8'h55, 1'b1, 1'b0, 1'b0);
    drive(8'h55, 1'b1, 1'b0, 1'b0);
    drive(8'h57, 1'b1, 1'b0, 1'b0);
    drive(8'hD5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(8'(i), 1'b1, 1'b0, 1'b0);
    idle(4);
    check("badpre_writes", 32'(wr_total - w0), 0);
    check("badpre_done", 32'(done_total - n0), 0);

    // PHY error on byte 20
    build_frame(64);
    w0 = wr_total; n0 = done_total;
    run_frame(64, -10, 20, -1);
    check_frame("phyerr", w0, n0, 60, 1, 0, 0, 0, 1, 0, 64);

    // Reset on byte 30: bytes 0..25 already written, nothing after
    build_frame(64);
    w0 = wr_total; n0 = done_total;
    run_frame(64, -10, -1, 30);
    check_frame("rstmid", w0, n0, 26, 0, 0, 0, 0, 0, 0, 0);

    // Clean frame after reset recovery
    build_frame(64);
    w0 = wr_total; n0 = done_total;
    run_frame(64, -10, -1, -1);
    check_frame("recover", w0, n0, 60, 1, 1, 0, 0, 0, 0, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
